frame_aligner: RTL and testbench
================================

# frame_aligner

Receive-side counterpart of the sender frame controller. It takes the serial byte stream of 4-row × 1041-column frames, finds and tracks the frame alignment signal (FAS), and recovers the frame row/column position. It also strips overhead and pad bytes and delivers payload bytes to the client side of the demapper. It sits between the line interface and the client payload sink.

## Interface
- `NUM_ROWS`, default 4: rows per frame.
- `NUM_COLS`, default 1041: columns per row.
  - Cols 0–15 are overhead.
  - Cols 16–1039 are payload.
  - Col 1040 is pad.
- `OH_COLS`, default 16: overhead columns per row.
- `LOSS_THRESH`, default 3: consecutive FAS misses in SYNC that force SEARCH.

Ports:
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst`  in  1  reset; asynchronous assert, active-low, release synchronous to `i_clk`.
- `i_frame_data`  in  8  line byte.
- `i_frame_data_valid`  in  1  qualifies `i_frame_data`; when low, all state holds.
- `o_pyld_data`  out  8  recovered payload byte.
- `o_pyld_data_valid`  out  1  high for payload bytes only, and only in SYNC.
- `o_row_cnt`  out  2  row of the byte accepted on the previous valid cycle.
- `o_col_cnt`  out  11  column of the byte accepted on the previous valid cycle.
- `o_frame_sync`  out  1  high while in SYNC.
- `o_fas_err`  out  1  one-cycle pulse on each FAS miss while in PRESYNC or SYNC.

## Operation
- FAS pattern: bytes F6 F6 F6 28 28 28 at row 0, cols 0–5.
- A 6-byte shift register captures the last six valid bytes. It advances only when `i_frame_data_valid` is high.
- `fas_match` is true when the shift register equals F6F6F6282828, with the newest byte = 28.
- State machine:
  - SEARCH:
    - Counters are free-running but meaningless.
    - On `fas_match`, the byte that completed the match is defined as row 0, col 5, and the state goes to PRESYNC.
  - PRESYNC:
    - Counters advance normally.
    - At the next row 0, col 5 with `fas_match`, go to SYNC.
    - At row 0, col 5 without `fas_match`, pulse `o_fas_err` and go to SEARCH.
  - SYNC:
    - At each row 0, col 5, `fas_match` clears the miss counter.
    - A miss increments the miss counter and pulses `o_fas_err`.
    - When the miss counter reaches `LOSS_THRESH`, go to SEARCH and clear the miss counter.
- Counter rules:
  - Col wraps from `NUM_COLS-1` to 0 and increments row.
  - Row wraps from `NUM_ROWS-1` to 0.
  - All widths are unsigned.
- Payload extraction, in SYNC only:
  - Bytes at cols `OH_COLS` to `NUM_COLS-2` on every row are forwarded.
  - Overhead bytes and col 1040 are never forwarded.
- Entering SYNC at row 0, col 5 means payload from row 0, col 16 of that same frame is delivered.
- A loss of sync takes effect on the byte after the failing col 5, so no payload of that frame is delivered.
- FAS-like data inside the payload is ignored outside SEARCH.

## Timing
- Reset values:
  - All outputs 0.
  - State SEARCH.
  - Shift register 0.
  - Counters 0.
  - Miss count 0.
- Latency: a byte accepted at cycle N appears on `o_pyld_data`/`o_pyld_data_valid` at N+1.
- `o_row_cnt`, `o_col_cnt`, `o_frame_sync` and `o_fas_err` are registered and aligned with the same N+1 output.
- `o_pyld_data_valid` is low in any cycle following an invalid input cycle.
- `o_pyld_data` holds its last value when not valid.
- `o_frame_sync` rises at N+1 for the col-5 byte that confirms PRESYNC→SYNC.
- `o_frame_sync` falls at N+1 for the col-5 byte of the `LOSS_THRESH`-th miss.
- Gaps in `i_frame_data_valid` of any length do not change alignment.
- Reset mid-frame: immediate return to SEARCH; a full two-frame reacquisition is required.

## Structure
- Shared package `frame_pkg` holds:
  - FAS byte constants `FAS_A=8'hF6`, `FAS_B=8'h28`.
  - `NUM_ROWS`, `NUM_COLS`, `OH_COLS`.
  - The aligner state encoding (SEARCH/PRESYNC/SYNC).
- The sender frame controller uses the same package.
- Sub-module `fas_detector`: 6-byte shift register plus comparator, with valid-gated shift, output `fas_match`.
- The top level owns the FSM, counters, miss counter and output registers.

## Test plan
- **Acquisition:** two clean frames, continuous valid.
  - `o_frame_sync` rises after the row 0, col 5 byte of frame 2.
  - The first `o_pyld_data_valid` carries row 0, col 16 of frame 2.
  - Exactly 4096 payload bytes per frame thereafter.
- **False lock:** random data containing one F6F6F6282828 sequence, no repeat at +4164 bytes.
  - SEARCH→PRESYNC→SEARCH.
  - One `o_fas_err` pulse.
  - `o_frame_sync` stays 0.
  - No payload output.
- **Loss of sync:** in SYNC, corrupt FAS in 2 consecutive frames, then send a clean frame.
  - Two `o_fas_err` pulses.
  - Sync is held.
  - The miss counter clears.
- **Loss of sync, continued:** corrupt FAS in 3 consecutive frames.
  - `o_frame_sync` falls at the third col 5.
  - No further payload output.
- **Valid gaps:** random `i_frame_data_valid` at 50% duty in SYNC.
  - Payload sequence is identical to the gap-free case.
  - `o_col_cnt` wraps 1040→0 and `o_row_cnt` wraps 3→0 correctly.
- **Reset mid-frame:** assert `i_rst` low at row 2, col 500 in SYNC.
  - All outputs are 0 asynchronously.
  - After release, reacquisition takes two clean FAS occurrences.

Source files
------------

// File: rtl/frame_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
// Shared definitions for the 4-row x 1041-column framing used by the sender
// frame controller and the receive-side frame_aligner.
//   - FAS bytes and the full 6-byte alignment word
//   - default frame geometry (rows, columns, overhead columns)
//   - counter widths used on the aligner position outputs
//   - aligner state encoding
// -----------------------------------------------------------------------------
package frame_pkg;

  // Default frame geometry
  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 1041;
  localparam int unsigned OH_COLS  = 16;

  // Position counter widths (row 0..3, col 0..1040)
  localparam int unsigned ROW_W = 2;
  localparam int unsigned COL_W = 11;

  // Frame alignment signal: F6 F6 F6 28 28 28 at row 0, cols 0..5
  localparam logic [7:0]  FAS_A   = 8'hF6;
  localparam logic [7:0]  FAS_B   = 8'h28;
  localparam int unsigned FAS_LEN = 6;
  localparam logic [FAS_LEN*8-1:0] FAS_PATTERN =
    {FAS_A, FAS_A, FAS_A, FAS_B, FAS_B, FAS_B};

  // Aligner state encoding
  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_PRESYNC = 2'd1,
    ST_SYNC    = 2'd2
  } align_state_t;

  // True for columns carrying client payload: after the overhead block and
  // before the single trailing pad column.
  function automatic logic is_payload_col(
    input logic [COL_W-1:0] col,
    input int unsigned      oh_cols,
    input int unsigned      num_cols
  );
    return (32'(col) >= oh_cols) && ((32'(col) + 32'd2) <= num_cols);
  endfunction

endpackage

// File: rtl/frame_aligner_fas_detector.sv
// -----------------------------------------------------------------------------
// fas_detector
// Six-byte shift register over the accepted line bytes plus a comparator
// against the frame alignment word.
// Ports:
//   i_clk         clock
//   i_rst         asynchronous active-low reset
//   i_data        line byte
//   i_data_valid  qualifies i_data; the shift register only advances when high
//   o_fas_match   the byte accepted this cycle completes F6F6F6282828
// -----------------------------------------------------------------------------
module fas_detector
  import frame_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  output logic       o_fas_match
);

  logic [FAS_LEN*8-1:0] r_shift;
  logic [FAS_LEN*8-1:0] w_shift_nxt;

  // Newest byte enters at the low end.
  assign w_shift_nxt = {r_shift[(FAS_LEN-1)*8-1:0], i_data};

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_shift <= '0;
    end else if (i_data_valid) begin
      r_shift <= w_shift_nxt;
    end
  end

  // Compare the register contents as they will be after this byte is shifted
  // in, so the match is reported on the same cycle as the completing byte and
  // the aligner can tag that very byte as row 0, col 5.
  assign o_fas_match = i_data_valid && (w_shift_nxt == FAS_PATTERN);

endmodule

// File: rtl/frame_aligner.sv
// -----------------------------------------------------------------------------
// frame_aligner
// Receive-side frame alignment and payload demapper. Finds the FAS in the
// serial byte stream, tracks row/column position, and forwards payload bytes
// (cols OH_COLS..NUM_COLS-2) only while frame sync is held.
// Ports:
//   i_clk               clock, rising edge
//   i_rst               asynchronous active-low reset
//   i_frame_data        line byte
//   i_frame_data_valid  qualifies i_frame_data; when low all state holds
//   o_pyld_data         recovered payload byte (holds when not valid)
//   o_pyld_data_valid   payload strobe, one cycle after the accepted byte
//   o_row_cnt           row of the previously accepted byte
//   o_col_cnt           column of the previously accepted byte
//   o_frame_sync        high while in SYNC
//   o_fas_err           one-cycle pulse per FAS miss in PRESYNC/SYNC
// -----------------------------------------------------------------------------
module frame_aligner #(
  parameter int unsigned NUM_ROWS    = frame_pkg::NUM_ROWS,
  parameter int unsigned NUM_COLS    = frame_pkg::NUM_COLS,
  parameter int unsigned OH_COLS     = frame_pkg::OH_COLS,
  parameter int unsigned LOSS_THRESH = 3
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [7:0]                  i_frame_data,
  input  logic                        i_frame_data_valid,
  output logic [7:0]                  o_pyld_data,
  output logic                        o_pyld_data_valid,
  output logic [frame_pkg::ROW_W-1:0] o_row_cnt,
  output logic [frame_pkg::COL_W-1:0] o_col_cnt,
  output logic                        o_frame_sync,
  output logic                        o_fas_err
);

  import frame_pkg::*;

  localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(NUM_COLS - 1);
  localparam logic [COL_W-1:0]  FAS_COL    = COL_W'(FAS_LEN - 1);
  localparam int unsigned       MISS_W     = $clog2(LOSS_THRESH + 1);
  localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(LOSS_THRESH);

  // FSM state
  align_state_t r_state;
  align_state_t w_state_nxt;

  // Position the next accepted byte will be given
  logic [ROW_W-1:0]  r_row_exp;
  logic [COL_W-1:0]  r_col_exp;

  // Consecutive FAS misses while in SYNC
  logic [MISS_W-1:0] r_miss;
  logic [MISS_W-1:0] w_miss_nxt;
  logic [MISS_W-1:0] w_miss_inc;

  // Output registers
  logic [7:0]        r_pyld_data;
  logic              r_pyld_vld;
  logic [ROW_W-1:0]  r_row_cnt;
  logic [COL_W-1:0]  r_col_cnt;
  logic              r_frame_sync;
  logic              r_fas_err;

  // Combinational decode of the byte currently offered
  logic              w_fas_match;
  logic              w_at_fas_pos;
  logic [ROW_W-1:0]  w_cur_row;
  logic [COL_W-1:0]  w_cur_col;
  logic [ROW_W-1:0]  w_row_nxt;
  logic [COL_W-1:0]  w_col_nxt;
  logic              w_fas_err;
  logic              w_is_pyld;

  fas_detector u_fas_detector (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_data       (i_frame_data),
    .i_data_valid (i_frame_data_valid),
    .o_fas_match  (w_fas_match)
  );

  assign w_at_fas_pos = (r_row_exp == '0) && (r_col_exp == FAS_COL);
  assign w_miss_inc   = r_miss + 1'b1;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_SEARCH;
    end else if (i_frame_data_valid) begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, miss count, FAS error and position of the current byte
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_miss_nxt  = r_miss;
    w_fas_err   = 1'b0;
    w_cur_row   = r_row_exp;
    w_cur_col   = r_col_exp;

    if (i_frame_data_valid) begin
      case (r_state)
        ST_SEARCH: begin
          // The byte completing the FAS becomes row 0, col 5; the counters
          // are re-seeded from here rather than from their free-running value.
          if (w_fas_match) begin
            w_cur_row   = '0;
            w_cur_col   = FAS_COL;
            w_state_nxt = ST_PRESYNC;
          end
        end

        ST_PRESYNC: begin
          if (w_at_fas_pos) begin
            if (w_fas_match) begin
              w_state_nxt = ST_SYNC;
            end else begin
              w_fas_err   = 1'b1;
              w_state_nxt = ST_SEARCH;
            end
          end
        end

        ST_SYNC: begin
          if (w_at_fas_pos) begin
            if (w_fas_match) begin
              w_miss_nxt = '0;
            end else begin
              w_fas_err = 1'b1;
              if (w_miss_inc == MISS_LIMIT) begin
                w_miss_nxt  = '0;
                w_state_nxt = ST_SEARCH;
              end else begin
                w_miss_nxt = w_miss_inc;
              end
            end
          end
        end

        default: begin
          w_state_nxt = ST_SEARCH;
          w_miss_nxt  = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Position advance and payload qualification
  // ---------------------------------------------------------------------------
  always_comb begin
    w_row_nxt = w_cur_row;
    w_col_nxt = w_cur_col + 1'b1;
    if (w_cur_col == LAST_COL) begin
      w_col_nxt = '0;
      w_row_nxt = (w_cur_row == LAST_ROW) ? '0 : (w_cur_row + 1'b1);
    end
  end

  // Payload is decided on the state before this byte's transition: the col-5
  // byte that confirms or loses sync is overhead either way, so sync changes
  // take effect from the following byte.
  assign w_is_pyld = i_frame_data_valid && (r_state == ST_SYNC) &&
                     is_payload_col(w_cur_col, OH_COLS, NUM_COLS);

  // ---------------------------------------------------------------------------
  // Counters, miss count and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_row_exp    <= '0;
      r_col_exp    <= '0;
      r_miss       <= '0;
      r_pyld_data  <= '0;
      r_pyld_vld   <= 1'b0;
      r_row_cnt    <= '0;
      r_col_cnt    <= '0;
      r_frame_sync <= 1'b0;
      r_fas_err    <= 1'b0;
    end else begin
      r_fas_err  <= w_fas_err;
      r_pyld_vld <= w_is_pyld;
      if (i_frame_data_valid) begin
        r_row_exp    <= w_row_nxt;
        r_col_exp    <= w_col_nxt;
        r_miss       <= w_miss_nxt;
        r_row_cnt    <= w_cur_row;
        r_col_cnt    <= w_cur_col;
        r_frame_sync <= (w_state_nxt == ST_SYNC);
        if (w_is_pyld) begin
          r_pyld_data <= i_frame_data;
        end
      end
    end
  end

  assign o_pyld_data       = r_pyld_data;
  assign o_pyld_data_valid = r_pyld_vld;
  assign o_row_cnt         = r_row_cnt;
  assign o_col_cnt         = r_col_cnt;
  assign o_frame_sync      = r_frame_sync;
  assign o_fas_err         = r_fas_err;

endmodule

// File: tb/tb_frame_aligner.sv
// -----------------------------------------------------------------------------
// tb_frame_aligner
// Directed bench for frame_aligner: acquisition, tolerated FAS misses, loss of
// sync, valid gaps, mid-frame reset and a false lock on random data.
// -----------------------------------------------------------------------------
module tb_frame_aligner;

  localparam int unsigned ROWS        = 4;
  localparam int unsigned COLS        = 1041;
  localparam int unsigned FRAME_BYTES = ROWS * COLS;
  localparam int unsigned PYLD_BYTES  = 4096;
  localparam int unsigned NO_STOP     = 32'hFFFF_FFFF;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [7:0]  i_frame_data = 8'h00;
  logic        i_frame_data_valid = 1'b0;
  logic [7:0]  o_pyld_data;
  logic        o_pyld_data_valid;
  logic [1:0]  o_row_cnt;
  logic [10:0] o_col_cnt;
  logic        o_frame_sync;
  logic        o_fas_err;

  frame_aligner #(
    .NUM_ROWS    (4),
    .NUM_COLS    (1041),
    .OH_COLS     (16),
    .LOSS_THRESH (3)
  ) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_frame_data       (i_frame_data),
    .i_frame_data_valid (i_frame_data_valid),
    .o_pyld_data        (o_pyld_data),
    .o_pyld_data_valid  (o_pyld_data_valid),
    .o_row_cnt          (o_row_cnt),
    .o_col_cnt          (o_col_cnt),
    .o_frame_sync       (o_frame_sync),
    .o_fas_err          (o_fas_err)
  );

  always #5 i_clk = ~i_clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Observation state
  // ---------------------------------------------------------------------------
  int unsigned frame_no = 0;
  int unsigned cur_row = 0, cur_col = 0;
  bit          pos_chk = 0;
  int unsigned pyld_cnt = 0, err_cnt = 0;
  int unsigned pd_bad = 0, pos_bad = 0, gap_vld_bad = 0, hold_bad = 0;
  int unsigned rise_cnt = 0, rise_frame = 0, rise_row = 0, rise_col = 0;
  int unsigned fall_cnt = 0, fall_frame = 0, fall_row = 0, fall_col = 0;
  bit          first_seen = 0;
  int unsigned first_frame = 0, first_row = 0, first_col = 0;
  logic [31:0] hash = '0, ref_hash = '0;
  logic [7:0]  exp_pdata = 8'h00;
  logic        prev_sync = 1'b0;
  int unsigned prev_row_obs = 0, prev_col_obs = 0, col_wraps = 0, row_wraps = 0;

  function automatic logic [7:0] gen_byte(input int unsigned cid, input int unsigned row,
                                          input int unsigned col, input bit corrupt);
    if (row == 0 && col < 6) begin
      if (corrupt && col == 4) return 8'h00;
      return (col < 3) ? 8'hF6 : 8'h28;
    end
    // Neighbouring bytes in a row differ by one, so no FAS can appear here.
    return 8'(col + row * 5 + cid * 11);
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic v);
    i_frame_data       = d;
    i_frame_data_valid = v;
    @(posedge i_clk);
    #1;
    if (o_fas_err) err_cnt++;
    if (o_frame_sync && !prev_sync) begin
      rise_cnt++; rise_frame = frame_no; rise_row = cur_row; rise_col = cur_col;
    end
    if (!o_frame_sync && prev_sync) begin
      fall_cnt++; fall_frame = frame_no; fall_row = cur_row; fall_col = cur_col;
    end
    prev_sync = o_frame_sync;
    if (o_pyld_data_valid) begin
      if (!v) begin
        gap_vld_bad++;
      end else begin
        if (o_pyld_data !== d) pd_bad++;
        exp_pdata = d;
        pyld_cnt++;
        hash = hash * 32'd31 + 32'(d);
        if (!first_seen) begin
          first_seen = 1; first_frame = frame_no; first_row = cur_row; first_col = cur_col;
        end
      end
    end else if (o_pyld_data !== exp_pdata) begin
      hold_bad++;
    end
    if (v) begin
      if (pos_chk) begin
        if (32'(o_row_cnt) != cur_row || 32'(o_col_cnt) != cur_col) pos_bad++;
        if (o_col_cnt == 11'd0 && prev_col_obs == 1040) col_wraps++;
        if (o_row_cnt == 2'd0 && prev_row_obs == 3) row_wraps++;
      end
      prev_row_obs = 32'(o_row_cnt);
      prev_col_obs = 32'(o_col_cnt);
    end
  endtask

  task automatic send_frame(input int unsigned cid, input bit corrupt, input bit gaps,
                            input int unsigned stop_idx);
    frame_no++;
    pyld_cnt = 0;
    hash     = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (r * COLS + c == stop_idx) return;
        cur_row = r;
        cur_col = c;
        if (gaps) begin
          while ($urandom_range(0, 1) == 1) send_byte(8'($urandom), 1'b0);
        end
        send_byte(gen_byte(cid, r, c, corrupt), 1'b1);
      end
    end
  endtask

  task automatic clear_obs();
    prev_sync  = 1'b0;
    exp_pdata  = 8'h00;
    pos_chk    = 0;
    rise_cnt   = 0;
    fall_cnt   = 0;
    err_cnt    = 0;
    first_seen = 0;
  endtask

  task automatic do_reset();
    i_frame_data_valid = 1'b0;
    i_rst = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    clear_obs();
  endtask

  task automatic check_all_zero(input string phase);
    check({phase, "_sync"}, 32'(o_frame_sync), 0);
    check({phase, "_pvld"}, 32'(o_pyld_data_valid), 0);
    check({phase, "_pdata"}, 32'(o_pyld_data), 0);
    check({phase, "_row"}, 32'(o_row_cnt), 0);
    check({phase, "_col"}, 32'(o_col_cnt), 0);
    check({phase, "_err"}, 32'(o_fas_err), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state
    i_rst = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_all_zero("rst");
    i_rst = 1'b1;
    clear_obs();

    // Acquisition: sync confirmed at row 0, col 5 of the second frame
    send_frame(1, 0, 0, NO_STOP);
    check("acq_f1_pyld", pyld_cnt, 0);
    check("acq_f1_rise", rise_cnt, 0);
    pos_chk = 1;
    send_frame(2, 0, 0, NO_STOP);
    check("acq_rise_cnt", rise_cnt, 1);
    check("acq_rise_frame", rise_frame, 2);
    check("acq_rise_row", rise_row, 0);
    check("acq_rise_col", rise_col, 5);
    check("acq_first_frame", first_frame, 2);
    check("acq_first_row", first_row, 0);
    check("acq_first_col", first_col, 16);
    check("acq_f2_pyld", pyld_cnt, PYLD_BYTES);
    send_frame(3, 0, 0, NO_STOP);
    check("acq_f3_pyld", pyld_cnt, PYLD_BYTES);
    check("acq_err", err_cnt, 0);

    // Two misses are tolerated and a clean frame clears the miss count
    err_cnt = 0;
    send_frame(4, 1, 0, NO_STOP);
    check("miss_f4_pyld", pyld_cnt, PYLD_BYTES);
    send_frame(5, 1, 0, NO_STOP);
    check("miss_f5_pyld", pyld_cnt, PYLD_BYTES);
    send_frame(6, 0, 0, NO_STOP);
    check("miss_f6_pyld", pyld_cnt, PYLD_BYTES);
    check("miss_err", err_cnt, 2);
    check("miss_sync_held", 32'(o_frame_sync), 1);
    check("miss_no_fall", fall_cnt, 0);

    // Third consecutive miss drops sync at col 5 of that frame
    err_cnt = 0;
    send_frame(7, 1, 0, NO_STOP);
    check("loss_f7_pyld", pyld_cnt, PYLD_BYTES);
    send_frame(8, 1, 0, NO_STOP);
    check("loss_f8_pyld", pyld_cnt, PYLD_BYTES);
    check("loss_f8_sync", 32'(o_frame_sync), 1);
    send_frame(9, 1, 0, NO_STOP);
    check("loss_f9_pyld", pyld_cnt, 0);
    check("loss_fall_cnt", fall_cnt, 1);
    check("loss_fall_frame", fall_frame, 9);
    check("loss_fall_row", fall_row, 0);
    check("loss_fall_col", fall_col, 5);
    check("loss_err", err_cnt, 3);
    check("loss_sync", 32'(o_frame_sync), 0);

    // Reacquire, then replay the last frame with ~50% valid duty
    pos_chk  = 0;
    rise_cnt = 0;
    err_cnt  = 0;
    send_frame(10, 0, 0, NO_STOP);
    check("reacq_f10_pyld", pyld_cnt, 0);
    check("reacq_f10_rise", rise_cnt, 0);
    pos_chk = 1;
    send_frame(11, 0, 0, NO_STOP);
    check("reacq_rise_frame", rise_frame, 11);
    check("reacq_f11_pyld", pyld_cnt, PYLD_BYTES);
    ref_hash  = hash;
    col_wraps = 0;
    row_wraps = 0;
    send_frame(11, 0, 1, NO_STOP);
    check("gap_pyld", pyld_cnt, PYLD_BYTES);
    check("gap_hash", hash, ref_hash);
    check("gap_col_wraps", col_wraps, 4);
    check("gap_row_wraps", row_wraps, 1);
    check("gap_vld_after_idle", gap_vld_bad, 0);
    check("gap_err", err_cnt, 0);
    check("pyld_data", pd_bad, 0);
    check("position", pos_bad, 0);
    check("pdata_hold", hold_bad, 0);

    // Reset in the middle of a synced frame: outputs clear without a clock
    send_frame(13, 0, 0, 2 * COLS + 500);
    check("mrst_pre_sync", 32'(o_frame_sync), 1);
    check("mrst_pre_pvld", 32'(o_pyld_data_valid), 1);
    #2;
    i_frame_data_valid = 1'b0;
    i_rst = 1'b0;
    #1;
    check_all_zero("mrst");
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    clear_obs();
    send_frame(14, 0, 0, NO_STOP);
    check("mrst_f14_pyld", pyld_cnt, 0);
    check("mrst_f14_rise", rise_cnt, 0);
    pos_chk = 1;
    send_frame(15, 0, 0, NO_STOP);
    check("mrst_rise_frame", rise_frame, 15);
    check("mrst_f15_pyld", pyld_cnt, PYLD_BYTES);
    check("mrst_position", pos_bad, 0);

    // False lock: a single FAS in random data, not repeated one frame later
    do_reset();
    pyld_cnt = 0;
    for (int unsigned k = 0; k < 100; k++) send_byte(8'($urandom), 1'b1);
    for (int unsigned k = 0; k < 6; k++) send_byte((k < 3) ? 8'hF6 : 8'h28, 1'b1);
    for (int unsigned k = 0; k < FRAME_BYTES - 1; k++) send_byte(8'($urandom), 1'b1);
    check("false_err_before", err_cnt, 0);
    send_byte(8'($urandom), 1'b1);
    check("false_err_at_col5", err_cnt, 1);
    for (int unsigned k = 0; k < 200; k++) send_byte(8'($urandom), 1'b1);
    check("false_err_total", err_cnt, 1);
    check("false_rise", rise_cnt, 0);
    check("false_sync", 32'(o_frame_sync), 0);
    check("false_pyld", pyld_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1);
  end

endmodule
